sd_seq_gen: RTL

//  Serial pattern generator. Transmit-side counterpart of the sequence detectors.

---
 rtl/sd_pkg.sv | 12 +
 rtl/sd_shift_out.sv | 31 +++
 rtl/sd_seq_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the serial sequence generator/detector family.
package sd_pkg;

  typedef enum logic [1:0] {
    SG_IDLE  = 2'b00,
    SG_SHIFT = 2'b01,
    SG_GAP   = 2'b10
  } sg_state_e;

  localparam logic [3:0] SD_PAT_1001 = 4'b1001;

endpackage

// File: rtl/sd_shift_out.sv
// Parallel-load rotating shift register with a registered MSB-first serial output.
// The stored pattern rotates back to its loaded value after PAT_W shifts, so repeats need no reload.
module sd_shift_out #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat,
  output logic             dout
);

  logic [PAT_W-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      dout <= 1'b0;
    end else if (load) begin
      sr   <= {pat[PAT_W-2:0], pat[PAT_W-1]};
      dout <= pat[PAT_W-1];
    end else if (shift) begin
      sr   <= {sr[PAT_W-2:0], sr[PAT_W-1]};
      dout <= sr[PAT_W-1];
    end else begin
      dout <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_seq_gen.sv
// Serial pattern generator: loads a pattern plus repeat count and shifts it out MSB-first.
// Define SD_IDLE_GAP_EN to insert GAP_LEN idle cycles between repeats.
module sd_seq_gen
  import sd_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    BW      = $clog2(PAT_W);
  localparam logic [BW-1:0]  IDX_MAX = BW'(PAT_W - 1);

  sg_state_e        state, state_n;
  logic [BW-1:0]    bit_idx, bit_idx_n;
  logic [CNT_W-1:0] reps_left, reps_left_n;
  logic             sr_load, sr_shift, done_n;

`ifdef SD_IDLE_GAP_EN
  localparam int unsigned GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
`endif

  sd_shift_out #(.PAT_W(PAT_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .pat   (pat_in),
    .dout  (dout)
  );

  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    reps_left_n = reps_left;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    done_n      = 1'b0;
`ifdef SD_IDLE_GAP_EN
    gap_cnt_n   = gap_cnt;
`endif
    case (state)
      SG_IDLE: begin
        if (load_valid) begin
          state_n     = SG_SHIFT;
          bit_idx_n   = IDX_MAX;
          reps_left_n = (rep_in == '0) ? CNT_W'(1) : rep_in;
          sr_load     = 1'b1;
        end
      end
      SG_SHIFT: begin
        if (abort) begin
          state_n     = SG_IDLE;
          bit_idx_n   = '0;
          reps_left_n = '0;
        end else if (bit_idx != '0) begin
          bit_idx_n = bit_idx - BW'(1);
          sr_shift  = 1'b1;
        end else if (reps_left > CNT_W'(1)) begin
          reps_left_n = reps_left - CNT_W'(1);
          bit_idx_n   = IDX_MAX;
`ifdef SD_IDLE_GAP_EN
          state_n     = SG_GAP;
          gap_cnt_n   = GW'(GAP_LEN - 1);
`else
          sr_shift    = 1'b1;
`endif
        end else begin
          state_n     = SG_IDLE;
          reps_left_n = '0;
          done_n      = 1'b1;
        end
      end
`ifdef SD_IDLE_GAP_EN
      SG_GAP: begin
        if (abort) begin
          state_n     = SG_IDLE;
          bit_idx_n   = '0;
          reps_left_n = '0;
          gap_cnt_n   = '0;
        end else if (gap_cnt == '0) begin
          state_n  = SG_SHIFT;
          sr_shift = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - GW'(1);
        end
      end
`endif
      default: state_n = SG_IDLE;
    endcase
  end

  // Flags are registered from the next-state decode so they line up with the registered dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SG_IDLE;
      bit_idx    <= '0;
      reps_left  <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
`ifdef SD_IDLE_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      reps_left  <= reps_left_n;
      dout_valid <= (state_n == SG_SHIFT);
      busy       <= (state_n != SG_IDLE);
      done       <= done_n;
      load_ready <= (state_n == SG_IDLE);
`ifdef SD_IDLE_GAP_EN
      gap_cnt    <= gap_cnt_n;
`endif
    end
  end

endmodule
